// File: rtl/uart_rx_deserializer_if.sv
// Write-side bundle between the UART receive deserializer and its FIFO.
// The deserializer drives the strobe, data and status; the FIFO returns full.
interface uart_rx_deserializer_if #(
  parameter int DATA_BITS = 8
);
  logic                 full_i;
  logic                 wr_o;
  logic [DATA_BITS-1:0] data_o;
  logic                 frame_error_o;
  logic                 parity_error_o;
  logic                 overrun_o;
  logic                 busy_o;

  modport master (
    input  full_i,
    output wr_o,
    output data_o,
    output frame_error_o,
    output parity_error_o,
    output overrun_o,
    output busy_o
  );

  modport slave (
    output full_i,
    input  wr_o,
    input  data_o,
    input  frame_error_o,
    input  parity_error_o,
    input  overrun_o,
    input  busy_o
  );
endinterface

// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: oversampled start/data/parity/stop framing,
// one write strobe per good character plus framing/parity/overrun pulses.
module uart_rx_deserializer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic rx_i,
  uart_rx_deserializer_if.master fifo
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int BW   = $clog2(DATA_BITS + 3);

  localparam logic [CW-1:0] SAMPLE_AT = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS);
  localparam logic          ODD       = 1'(PARITY_ODD);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_e;

  state_e               state_q, state_d;
  logic                 sync1_q, rx_s_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 par_ok_q, par_ok_d;
  logic                 wr_q, wr_d;
  logic                 fe_q, fe_d;
  logic                 pe_q, pe_d;
  logic                 sample;

  assign sample = (cnt_q == SAMPLE_AT);

  always_comb begin
    state_d  = state_q;
    cnt_d    = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    data_d   = data_q;
    par_ok_d = par_ok_q;
    wr_d     = 1'b0;
    fe_d     = 1'b0;
    pe_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (sample) begin
          if (rx_s_q) begin
            state_d = S_IDLE;
          end else begin
            state_d  = S_DATA;
            bit_d    = BW'(1);
            par_ok_d = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (sample) begin
          shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == LAST_BIT)
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (sample) begin
          par_ok_d = (rx_s_q == ((^shift_q) ^ ODD));
          bit_d    = bit_q + 1'b1;
          state_d  = S_STOP;
        end
      end
      S_STOP: begin
        // Hold STOP for the strobe cycle, then leave on the recorded outcome.
        if (wr_q || pe_q) begin
          state_d = S_IDLE;
        end else if (fe_q) begin
          state_d = S_BREAK;
        end else if (sample) begin
          if (!rx_s_q) begin
            fe_d = 1'b1;
          end else if (par_ok_q) begin
            wr_d   = 1'b1;
            data_d = shift_q;
          end else begin
            pe_d = 1'b1;
          end
        end
      end
      S_BREAK: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q  <= 1'b1;
      rx_s_q   <= 1'b1;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      par_ok_q <= 1'b1;
      wr_q     <= 1'b0;
      fe_q     <= 1'b0;
      pe_q     <= 1'b0;
    end else begin
      sync1_q  <= rx_i;
      rx_s_q   <= sync1_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      par_ok_q <= par_ok_d;
      wr_q     <= wr_d;
      fe_q     <= fe_d;
      pe_q     <= pe_d;
    end
  end

  assign fifo.wr_o           = wr_q;
  assign fifo.data_o         = data_q;
  assign fifo.frame_error_o  = fe_q;
  assign fifo.parity_error_o = pe_q;
  assign fifo.overrun_o      = wr_q & fifo.full_i;
  assign fifo.busy_o         = (state_q != S_IDLE);

endmodule
